// File: rtl/acc_unit_pkg.sv
// acc_unit_pkg: opcode and FSM state types shared by the accumulator block
package acc_unit_pkg;
  typedef enum logic [3:0] {
    OP_MOVF = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_COMF = 4'd6,
    OP_INC  = 4'd7,
    OP_DEC  = 4'd8,
    OP_RLC  = 4'd9,
    OP_RRC  = 4'd10,
    OP_CLR  = 4'd11,
    OP_MUL  = 4'd12,
    OP_NOP  = 4'd13
  } acc_op_e;
  typedef enum logic {IDLE, MUL} acc_state_e;
endpackage

// File: rtl/acc_unit_if.sv
// acc_unit_if: instruction handshake and result/status bundle of the accumulator
interface acc_unit_if #(parameter int WIDTH = 16, parameter int PC_W = 16);
  logic [3:0]       inst;
  logic [WIDTH-1:0] f;
  logic             inst_valid;
  logic             inst_ready;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] prod_hi;
  logic             carry;
  logic             zero;
  logic [PC_W-1:0]  counter;
  logic             done;
  logic             illegal;
  modport master (output inst, f, inst_valid,
                  input inst_ready, w, prod_hi, carry, zero, counter, done, illegal);
  modport slave (input inst, f, inst_valid,
                 output inst_ready, w, prod_hi, carry, zero, counter, done, illegal);
endinterface

// File: rtl/acc_unit_mul.sv
// acc_unit_mul: sequential shift-add multiplier, one partial product per cycle
module acc_unit_mul #(parameter int WIDTH = 16) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] a_q, hi, lo;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt;
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
  // product is the post-step value so the caller can capture it on the final step edge
  assign product = {sum, lo[WIDTH-1:1]};
  assign valid = busy && cnt == CW'(WIDTH - 1);
  // load operands on start, then add-and-shift right once per cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q <= a;
      hi <= '0;
      lo <= b;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      {hi, lo} <= product;
      cnt <= cnt + CW'(1);
      busy <= !valid;
    end
endmodule

// File: rtl/acc_unit.sv
// acc_unit: accumulator datapath with W register, flags, instruction counter (MUL via ACC_UNIT_MUL_EN)
module acc_unit
  import acc_unit_pkg::*;
#(parameter int WIDTH = 16, parameter int PC_W = 16) (
  input logic       clk,
  input logic       reset,
  acc_unit_if.slave bus
);
  acc_state_e         state, state_n;
  logic [WIDTH-1:0]   w, prod_hi, w_n;
  logic [PC_W-1:0]    counter;
  logic [2*WIDTH-1:0] prod;
  logic carry, zero, done, illegal, c_n, wr, ill, go_mul, accept, mul_busy, mul_valid;
  assign bus.inst_ready = !reset && state == IDLE;
  assign accept = bus.inst_valid && bus.inst_ready;
  assign bus.w = w;
  assign bus.prod_hi = prod_hi;
  assign bus.carry = carry;
  assign bus.zero = zero;
  assign bus.counter = counter;
  assign bus.done = done;
  assign bus.illegal = illegal;
`ifdef ACC_UNIT_MUL_EN
  acc_unit_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .reset(reset),
    .start(accept && go_mul),
    .a(w),
    .b(bus.f),
    .busy(mul_busy),
    .valid(mul_valid),
    .product(prod)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_valid = 1'b0;
  assign prod = '0;
`endif
  // decode the presented opcode into the next W/carry and its side effects
  always_comb begin
    w_n = w;
    c_n = carry;
    wr = 1'b1;
    ill = 1'b0;
    go_mul = 1'b0;
    case (bus.inst)
      OP_MOVF: w_n = bus.f;
      OP_ADD:  {c_n, w_n} = {1'b0, w} + {1'b0, bus.f};
      OP_SUB:  begin w_n = w - bus.f; c_n = w >= bus.f; end
      OP_AND:  w_n = w & bus.f;
      OP_OR:   w_n = w | bus.f;
      OP_XOR:  w_n = w ^ bus.f;
      OP_COMF: w_n = ~bus.f;
      OP_INC:  begin w_n = w + WIDTH'(1); c_n = &w; end
      OP_DEC:  begin w_n = w - WIDTH'(1); c_n = |w; end
      OP_RLC:  {c_n, w_n} = {w, carry};
      OP_RRC:  {w_n, c_n} = {carry, w};
      OP_CLR:  w_n = '0;
`ifdef ACC_UNIT_MUL_EN
      OP_MUL:  begin wr = 1'b0; go_mul = 1'b1; end
`endif
      OP_NOP:  wr = 1'b0;
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
  end
  // MUL is held until the multiplier reports its last step
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept && go_mul ? MUL : IDLE) : (mul_busy && !mul_valid ? MUL : IDLE);
  end
  // FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // architectural state: W, flags, counter and completion pulses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      w <= '0;
      prod_hi <= '0;
      carry <= 1'b0;
      zero <= 1'b1;
      counter <= '0;
      done <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= (accept && !go_mul) || mul_valid;
      illegal <= accept && ill;
      if (accept) counter <= counter + PC_W'(1);
      if (accept && wr) begin
        w <= w_n;
        carry <= c_n;
        zero <= w_n == '0;
      end
      if (mul_valid) begin
        {prod_hi, w} <= prod;
        carry <= |prod[2*WIDTH-1:WIDTH];
        zero <= prod[WIDTH-1:0] == '0;
      end
    end
endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: scoreboard bench for acc_unit, MUL checks follow ACC_UNIT_MUL_EN
module tb_acc_unit;
  import acc_unit_pkg::*;
`ifdef ACC_UNIT_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  typedef struct packed {
    logic [15:0] w;
    logic [15:0] ph;
    logic        c;
    logic        z;
    logic        ill;
    logic [15:0] cnt;
  } res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  res_t exp_q[$];
  res_t obs_q[$];
  string name_q[$];
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  acc_unit_if #(.WIDTH(16), .PC_W(16)) bus ();
  acc_unit #(.WIDTH(16), .PC_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(negedge clk)
    if (bus.done === 1'b1)
      obs_q.push_back({bus.w, bus.prod_hi, bus.carry, bus.zero, bus.illegal, bus.counter});
  task automatic send(input logic [3:0] op, input logic [15:0] fv, output int waits);
    bus.inst = op;
    bus.f = fv;
    bus.inst_valid = 1'b1;
    waits = 0;
    while (bus.inst_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: inst_ready=%b, want 1", bus.inst_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.inst_valid = 1'b0;
  endtask
  task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] fv,
                       input logic [15:0] ew, input logic [15:0] eph, input logic ec,
                       input logic ez, input logic eill, input logic [15:0] ecnt, output int waits);
    exp_q.push_back({ew, eph, ec, ez, eill, ecnt});
    name_q.push_back(nm);
    send(op, fv, waits);
  endtask
  task automatic test_reset;
    res_t o;
    bus.inst = 4'd0;
    bus.f = 16'd0;
    bus.inst_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    o = {bus.w, bus.prod_hi, bus.carry, bus.zero, bus.illegal, bus.counter};
    n_checks++;
    if (o !== res_t'({16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0})) begin
      n_fail++;
      $display("FAIL reset_state: got %h, want %h", o, res_t'({16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0}));
    end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, want 0", bus.done); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.inst_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, want 1", bus.inst_ready); end
  endtask
  task automatic test_alu_back_to_back;
    int wt;
    issue("movf10",   OP_MOVF, 16'd10,   16'd10,   0, 0, 0, 0, 16'd1,  wt);
    issue("add10",    OP_ADD,  16'd10,   16'd20,   0, 0, 0, 0, 16'd2,  wt);
    issue("add_cy",   OP_ADD,  16'hFFF0, 16'h0004, 0, 1, 0, 0, 16'd3,  wt);
    issue("movf3",    OP_MOVF, 16'd3,    16'd3,    0, 1, 0, 0, 16'd4,  wt);
    issue("sub_eq",   OP_SUB,  16'd3,    16'd0,    0, 1, 1, 0, 16'd5,  wt);
    issue("sub_brw",  OP_SUB,  16'd1,    16'hFFFF, 0, 0, 0, 0, 16'd6,  wt);
    issue("movf8001", OP_MOVF, 16'h8001, 16'h8001, 0, 0, 0, 0, 16'd7,  wt);
    issue("rlc",      OP_RLC,  16'd0,    16'h0002, 0, 1, 0, 0, 16'd8,  wt);
    issue("rrc",      OP_RRC,  16'd0,    16'h8001, 0, 0, 0, 0, 16'd9,  wt);
    issue("and",      OP_AND,  16'h00FF, 16'h0001, 0, 0, 0, 0, 16'd10, wt);
    issue("or",       OP_OR,   16'hF000, 16'hF001, 0, 0, 0, 0, 16'd11, wt);
    issue("xor",      OP_XOR,  16'hF001, 16'h0000, 0, 0, 1, 0, 16'd12, wt);
    issue("comf",     OP_COMF, 16'h00FF, 16'hFF00, 0, 0, 0, 0, 16'd13, wt);
    issue("inc",      OP_INC,  16'd0,    16'hFF01, 0, 0, 0, 0, 16'd14, wt);
    issue("movfffff", OP_MOVF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 16'd15, wt);
    issue("inc_wrap", OP_INC,  16'd0,    16'h0000, 0, 1, 1, 0, 16'd16, wt);
    issue("dec_wrap", OP_DEC,  16'd0,    16'hFFFF, 0, 0, 0, 0, 16'd17, wt);
    issue("dec",      OP_DEC,  16'd0,    16'hFFFE, 0, 1, 0, 0, 16'd18, wt);
    issue("clr",      OP_CLR,  16'h1234, 16'h0000, 0, 1, 1, 0, 16'd19, wt);
    issue("nop",      OP_NOP,  16'h5555, 16'h0000, 0, 1, 1, 0, 16'd20, wt);
    issue("illegal15", 4'd15,  16'h5555, 16'h0000, 0, 1, 1, 1, 16'd21, wt);
    while (exp_q.size() > 0) begin
      int t = 0;
      res_t e = exp_q.pop_front();
      string nm = name_q.pop_front();
      while (obs_q.size() == 0 && t < 40) begin @(negedge clk); t++; end
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: got no done pulse, want one", nm);
      end else begin
        res_t o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s: got w=%h ph=%h c=%b z=%b ill=%b cnt=%0d, want w=%h ph=%h c=%b z=%b ill=%b cnt=%0d",
                   nm, o.w, o.ph, o.c, o.z, o.ill, o.cnt, e.w, e.ph, e.c, e.z, e.ill, e.cnt);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL alu_extra_done: got %0d extra pulses, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask
  task automatic test_mul;
    int wt_mul, wt_next;
    issue("movf300", OP_MOVF, 16'd300, 16'd300, 0, 1, 0, 0, 16'd22, wt_mul);
    issue("mul", OP_MUL, 16'd300, MUL_ON ? 16'h5F90 : 16'd300, {15'd0, MUL_ON}, 1'b1, 1'b0, !MUL_ON, 16'd23, wt_mul);
    issue("held_movf7", OP_MOVF, 16'd7, 16'd7, {15'd0, MUL_ON}, 1'b1, 1'b0, 1'b0, 16'd24, wt_next);
    n_checks++;
    if (wt_next != (MUL_ON ? 16 : 0)) begin
      n_fail++;
      $display("FAIL mul_ready_low: got %0d cycles, want %0d", wt_next, MUL_ON ? 16 : 0);
    end
    while (exp_q.size() > 0) begin
      int t = 0;
      res_t e = exp_q.pop_front();
      string nm = name_q.pop_front();
      while (obs_q.size() == 0 && t < 40) begin @(negedge clk); t++; end
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: got no done pulse, want one", nm);
      end else begin
        res_t o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s: got w=%h ph=%h c=%b z=%b ill=%b cnt=%0d, want w=%h ph=%h c=%b z=%b ill=%b cnt=%0d",
                   nm, o.w, o.ph, o.c, o.z, o.ill, o.cnt, e.w, e.ph, e.c, e.z, e.ill, e.cnt);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL mul_extra_done: got %0d extra pulses, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask
  task automatic test_abort_illegal;
    int wt;
    res_t o;
    send(OP_MUL, 16'd5, wt);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    obs_q.delete();
    #1;
    o = {bus.w, bus.prod_hi, bus.carry, bus.zero, bus.illegal, bus.counter};
    n_checks++;
    if (o !== res_t'({16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0})) begin
      n_fail++;
      $display("FAIL abort_state: got %h, want %h", o, res_t'({16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0}));
    end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b, want 0", bus.done); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.inst_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b, want 1", bus.inst_ready); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || bus.w !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_no_result: got %0d done pulses w=%h, want 0 pulses w=0000", obs_q.size(), bus.w);
      obs_q.delete();
    end
    issue("illegal14", 4'd14, 16'h00AA, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 16'd1, wt);
    while (exp_q.size() > 0) begin
      int t = 0;
      res_t e = exp_q.pop_front();
      string nm = name_q.pop_front();
      while (obs_q.size() == 0 && t < 40) begin @(negedge clk); t++; end
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: got no done pulse, want one", nm);
      end else begin
        res_t r = obs_q.pop_front();
        if (r !== e) begin
          n_fail++;
          $display("FAIL %s: got w=%h ph=%h c=%b z=%b ill=%b cnt=%0d, want w=%h ph=%h c=%b z=%b ill=%b cnt=%0d",
                   nm, r.w, r.ph, r.c, r.z, r.ill, r.cnt, e.w, e.ph, e.c, e.z, e.ill, e.cnt);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || bus.illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse_width: got %0d extra done, illegal=%b, want 0 and 0", obs_q.size(), bus.illegal);
    end
  endtask
  initial begin
    test_reset();
    test_alu_back_to_back();
    test_mul();
    test_abort_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end
endmodule

// File: doc/acc_unit.md
# acc_unit

Parametrised accumulator datapath: the next-generation replacement for the separate ALU, W-register and program-counter trio, merged into one block with a valid/ready instruction handshake. It executes one opcode per accepted instruction against operand `f` and the internal W register, and maintains carry/zero status and an instruction counter. An optional multi-cycle shift-add multiplier is included when configured in. It sits between the instruction fetch/decode stage and the register file.

## Interface
- `WIDTH`, 16: data width of W, `f` and `prod_hi`.
- `PC_W`, 16: instruction counter width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `inst` in 4: opcode, sampled on accept.
- `f` in WIDTH: operand, sampled on accept.
- `inst_valid` in 1: instruction present.
- `inst_ready` out 1: block can accept.
- `w` out WIDTH: W register.
- `prod_hi` out WIDTH: high half of the last MUL result.
- `carry` out 1, `zero` out 1: status flags.
- `counter` out PC_W: count of accepted instructions.
- `done` out 1: one-cycle pulse in the cycle after W/flags update.
- `illegal` out 1: one-cycle pulse for an illegal opcode.

## Operation
- Accept = `inst_valid && inst_ready` at a rising edge. `counter` increments by 1 on every accept, including NOP and illegal opcodes, and wraps from all-ones to 0.
- Opcodes (A = WIDTH+1-bit intermediate):
  - 0 MOVF: w=f.
  - 1 ADD: A=w+f; w=A[WIDTH-1:0]; carry=A[WIDTH].
  - 2 SUB: w=w-f; carry=1 when w>=f (no borrow), else 0.
  - 3 AND, 4 OR, 5 XOR: bitwise with f; carry unchanged.
  - 6 COMF: w=~f; carry unchanged.
  - 7 INC: w=w+1; carry=1 only on wrap from all-ones to 0.
  - 8 DEC: w=w-1; carry=0 only on wrap from 0 to all-ones, else 1.
  - 9 RLC: {carry,w} rotated left by one.
  - 10 RRC: {w,carry} rotated right by one.
  - 11 CLR: w=0; carry unchanged.
  - 12 MUL: {prod_hi,w}=w*f, unsigned; carry=|prod_hi.
  - 13 NOP: no state change.
  - 14–15: illegal. No state change except `counter`; `illegal` pulses.
- `zero` = (new w == 0) for every opcode that writes w. It is unchanged for NOP and illegal opcodes.
- `done` pulses for every accepted instruction, including NOP and illegal.
- FSM states: IDLE and MUL.
  - IDLE: `inst_ready`=1. Accepting opcode 12 moves the FSM to MUL; every other opcode completes in IDLE.
  - MUL: `inst_ready`=0. Performs one shift-add step per cycle for WIDTH cycles, then writes the result and returns to IDLE.
- `inst_valid` held while `inst_ready`=0 is not accepted, and `inst`/`f` are not sampled. The upstream stage must hold the instruction stable until it is accepted.

## Timing
- Reset values: w=0, prod_hi=0, carry=0, zero=1, counter=0, done=0, illegal=0, FSM=IDLE. `inst_ready`=1 once reset is released.
- Single-cycle ops: accepted at edge k; w and flags updated at edge k; `done`/`illegal` high during cycle k..k+1. Back-to-back accepts are allowed every cycle.
- MUL: accepted at edge k; `inst_ready` low from edge k; result written at edge k+WIDTH; `done` high for the following cycle; `inst_ready` high again after edge k+WIDTH. Earliest next accept is edge k+WIDTH+1.
- Reset asserted mid-MUL aborts the multiply. All outputs return to their reset values immediately, and the partial product is discarded.
- MUL operands are captured at accept. Changes to `f` during MUL have no effect.

## Configuration
- `ACC_UNIT_MUL_EN` defined: opcode 12 is MUL as specified above, and the MUL state and multiplier are present.
- `ACC_UNIT_MUL_EN` undefined: opcode 12 is treated as illegal (pulses `illegal`, no state change). The FSM never leaves IDLE, `inst_ready` is constant 1 outside reset, and `prod_hi` is tied to 0.

## Structure
- Package `acc_unit_pkg`:
  - opcode enum `acc_op_e` (4-bit, values above);
  - FSM enum `acc_state_e` (IDLE, MUL).
- Sub-module `acc_unit_mul`: sequential shift-add multiplier. Interface: start, operands a/b, busy, valid, 2·WIDTH-bit product. Instantiated only under `ACC_UNIT_MUL_EN`.

## Test plan
All cases use WIDTH=16.
- Reset → w=0, carry=0, zero=1, counter=0, `inst_ready`=1.
- MOVF f=10, ADD f=10 → w=20, carry=0. Then ADD f=0xFFF0 → w=0x0004, carry=1, counter=3.
- MOVF f=3, SUB f=3 → w=0, zero=1, carry=1. Then SUB f=1 → w=0xFFFF, carry=0, zero=0.
- RLC on w=0x8001, carry=0 → w=0x0002, carry=1. Then RRC → w=0x8001, carry=0.
- MUL on w=300, f=300 → w=0x5F90, prod_hi=0x0001, carry=1. `inst_ready` low for 16 cycles; `done` pulses once. An instruction held valid during MUL is accepted only at the edge after completion.
- Reset pulsed 5 cycles into a MUL → outputs return to reset values. Then opcode 14 → `illegal` pulses, w unchanged, counter=1.
